two_bit_serial_adder: RTL and testbench
=======================================

Name: two_bit_serial_adder

Overview:
- Multi-cycle N-bit adder that consumes two operand bits per clock through one instance of the existing 2-bit full-adder cell (two_bit_fac).
- A carry flip-flop chains the slices, so an N-bit add takes N/2 run cycles.
- Sits directly above the 2-bit cell. It is the sequential stage that feeds the cell its operand slices and consumes its 3-bit result.
- Used where adder area matters more than latency.

Parameters:
- WIDTH, 8, operand/sum width in bits. Must be even and >= 2; a non-even value is a build-time error.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an add; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepted start edge.
- b  input  WIDTH  operand B, captured on the accepted start edge.
- carry_in  input  1  initial carry, captured on the accepted start edge.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; sum/carry_out are valid.
- sum  output  WIDTH  registered result, low WIDTH bits of a+b+carry_in.
- carry_out  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry_out=0, carry flop=0, slice counter=0, operand/partial shift registers=0.
- FSM:
  - IDLE -> RUN when start=1 at a rising edge.
    - Load a and b into shift registers.
    - Load carry_in into the carry flop.
    - Clear the counter and the partial sum.
  - RUN, each edge:
    - Feed the low 2 bits of the A/B shift registers plus the carry flop to two_bit_fac.
    - Store the cell's carry_out in the carry flop.
    - Shift the cell's 2-bit out into the top of the partial-sum register; shift A/B right by 2.
    - Counter increments. After the (WIDTH/2)th RUN edge: transfer the partial sum to sum and the carry flop to carry_out, then go to DONE.
  - DONE -> IDLE unconditionally on the next edge. done=1 only while in DONE.
- Latency: start sampled at edge E0 -> done=1 from edge E0+WIDTH/2+1 until E0+WIDTH/2+2. For WIDTH=8, done rises after edge 5.
- busy = 1 in RUN and DONE. start is ignored whenever busy=1, including the DONE cycle.
- Earliest back-to-back start is accepted on the edge after done falls.
- sum and carry_out change only on the RUN->DONE edge. They hold between operations and are never exposed mid-computation.
- a, b and carry_in may change freely after the start edge without effect.
- Reset asserted mid-operation:
  - Immediately return to IDLE with all reset values, including a cleared sum.
  - No done pulse is produced for the aborted add.
- Wrap-around: the sum is modulo 2^WIDTH; the overflow bit appears only in carry_out.

Optional Feature:
- Macro TWO_BIT_SERIAL_OVF_EN.
- When defined:
  - Adds output port overflow (1 bit), reset 0, updated on the same RUN->DONE edge as sum.
  - Value is two's-complement signed overflow: (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]), using the captured operands.
  - Holds until the next completion or reset.
- When undefined: the port, its register and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, carry_in=0, start pulse -> busy=1 next cycle; done=1 exactly after the 5th edge; sum=0x10, carry_out=0.
- WIDTH=8, a=0xFF, b=0x00, carry_in=1 -> sum=0x00, carry_out=1. Also: a=0xAA, b=0x55, carry_in=0 -> sum=0xFF, carry_out=0.
- start held high continuously with a=0x01, b=0x01, then operands changed mid-RUN to 0xFF/0xFF:
  - first result is sum=0x02, carry_out=0;
  - the second add is accepted only on the edge after done falls.
- Launch a=0x80, b=0x80, drop rst_n low for one cycle during RUN -> busy=0, done=0, sum=0x00 immediately; no done pulse; the next start adds correctly.
- WIDTH=4 exhaustive: all 16x16x2 combinations of a, b, carry_in -> {carry_out,sum} equals a+b+carry_in for every case; done occurs 3 edges after start.
- With TWO_BIT_SERIAL_OVF_EN, WIDTH=8:
  - a=0x7F, b=0x01 -> sum=0x80, overflow=1;
  - a=0xFF, b=0x01 -> sum=0x00, carry_out=1, overflow=0.

Source files
------------

// File: rtl/two_bit_serial_adder.sv
// two_bit_serial_adder: multi-cycle WIDTH-bit adder that feeds two operand
// bits per clock through a single 2-bit full-adder cell (two_bit_fac), with a
// carry flop chaining the slices. Trades latency for adder area.
//
// Optional feature: define TWO_BIT_SERIAL_OVF_EN to add the 'overflow' output
// (two's-complement signed overflow of the completed add).

// 2-bit ripple full-adder cell: o_out = {carry_out, sum[1:0]}.
module two_bit_fac (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  input  logic       i_cin,
  output logic [2:0] o_out
);
  logic w_c0;

  assign o_out[0] = i_a[0] ^ i_b[0] ^ i_cin;
  assign w_c0     = (i_a[0] & i_b[0]) | (i_cin & (i_a[0] ^ i_b[0]));
  assign o_out[1] = i_a[1] ^ i_b[1] ^ w_c0;
  assign o_out[2] = (i_a[1] & i_b[1]) | (w_c0 & (i_a[1] ^ i_b[1]));
endmodule

module two_bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef TWO_BIT_SERIAL_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int SLICES = WIDTH / 2;
  localparam int CW     = $clog2(SLICES + 1);

  // An odd or too-small width cannot be split into 2-bit slices.
  if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
    $error("two_bit_serial_adder: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_last;
  logic [2:0]       w_fac;
  logic [WIDTH+1:0] w_psum_ext;
`ifdef TWO_BIT_SERIAL_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  // The counter reaches SLICES once every slice has been added; the RUN edge
  // that sees this only publishes the result.
  assign w_last = (r_cnt == CW'(SLICES));

  two_bit_fac u_fac (
    .i_a   (r_a[1:0]),
    .i_b   (r_b[1:0]),
    .i_cin (r_carry),
    .o_out (w_fac)
  );

  // New 2-bit slice enters at the top; after SLICES shifts the first slice
  // has reached bit 0. Works for WIDTH=2 without an empty part-select.
  assign w_psum_ext = {w_fac[1:0], r_psum};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and status decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, slice-by-slice add, and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all datapath registers, including the visible sum, are reset so
    // an aborted add leaves no stale result behind.
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
`ifdef TWO_BIT_SERIAL_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= carry_in;
            r_psum  <= '0;
            r_cnt   <= '0;
`ifdef TWO_BIT_SERIAL_OVF_EN
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          if (!w_last) begin
            r_carry <= w_fac[2];
            r_psum  <= w_psum_ext[WIDTH+1:2];
            r_a     <= r_a >> 2;
            r_b     <= r_b >> 2;
            r_cnt   <= r_cnt + CW'(1);
          end else begin
            r_sum   <= r_psum;
            r_cout  <= r_carry;
`ifdef TWO_BIT_SERIAL_OVF_EN
            r_ovf   <= (r_a_msb == r_b_msb) && (r_psum[WIDTH-1] != r_a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;
`ifdef TWO_BIT_SERIAL_OVF_EN
  assign overflow  = r_ovf;
`endif

endmodule

// File: tb/tb_two_bit_serial_adder.sv
// Testbench for two_bit_serial_adder: table vectors, hand-written multi-cycle
// sequences, random adds against an arithmetic model (WIDTH=8), and an
// exhaustive WIDTH=4 sweep. Overflow checks compile in with
// TWO_BIT_SERIAL_OVF_EN.
module tb_two_bit_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, co;
  logic [7:0] sum;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4, co4;
  logic [3:0] sum4;
`ifdef TWO_BIT_SERIAL_OVF_EN
  logic       ovf, ovf4;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  two_bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (co)
`ifdef TWO_BIT_SERIAL_OVF_EN
    ,
    .overflow  (ovf)
`endif
  );

  two_bit_serial_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start4),
    .a         (a4),
    .b         (b4),
    .carry_in  (cin4),
    .busy      (busy4),
    .done      (done4),
    .sum       (sum4),
    .carry_out (co4)
`ifdef TWO_BIT_SERIAL_OVF_EN
    ,
    .overflow  (ovf4)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_co;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete WIDTH=8 add; operands are scrambled right after the start
  // edge. lat counts edges after the start edge until done is seen.
  task automatic add8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                      output logic [7:0] osum, output logic oco, output int lat);
    logic [7:0] held;
    bit         stable;
    held   = sum;
    stable = 1'b1;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; cin = icin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    check("busy_after_start", busy, 1);
    lat = 0;
    while (!done && lat < 20) begin
      if (sum !== held) stable = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("done_seen", done, 1);
    check("sum_hold_during_run", stable, 1);
    osum = sum;
    oco  = co;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_clear_after_done", busy, 0);
  endtask

  initial begin
    logic [7:0] s;
    logic       c;
    int         lat;
    bit         seen;

    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] s;
    logic       c;
    int         lat;
    bit         seen;
    logic [8:0] ref9;
    int         sa, sb, ssum;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_carry_out", co, 0);
`ifdef TWO_BIT_SERIAL_OVF_EN
    check("reset_overflow", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors; done must appear WIDTH/2+1 = 5 edges after start.
    for (int i = 0; i < 6; i++) begin
      add8(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, lat);
      check($sformatf("vec%0d_sum", i), s, vecs[i].exp_sum);
      check($sformatf("vec%0d_carry_out", i), c, vecs[i].exp_co);
      check($sformatf("vec%0d_latency", i), lat, 5);
    end

`ifdef TWO_BIT_SERIAL_OVF_EN
    add8(8'h7F, 8'h01, 1'b0, s, c, lat);
    check("ovf_7f_sum", s, 8'h80);
    check("ovf_7f_overflow", ovf, 1);
    add8(8'hFF, 8'h01, 1'b0, s, c, lat);
    check("ovf_ff_sum", s, 8'h00);
    check("ovf_ff_carry_out", c, 1);
    check("ovf_ff_overflow", ovf, 0);
`endif

    // start held high; operands change mid-RUN; second add only after done falls.
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF;
    check("hold_busy", busy, 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("hold_latency", lat, 5);
    check("hold_first_sum", sum, 8'h02);
    check("hold_first_carry_out", co, 0);
    @(posedge clk);
    @(negedge clk);
    check("hold_idle_after_done_busy", busy, 0);
    check("hold_idle_after_done_done", done, 0);
    @(posedge clk);
    @(negedge clk);
    check("hold_second_accepted", busy, 1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("hold_second_latency", lat, 5);
    check("hold_second_sum", sum, 8'hFE);
    check("hold_second_carry_out", co, 1);
    @(negedge clk);

    // Reset asserted during RUN: immediate clear, no done pulse, clean restart.
    start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_carry_out", co, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    add8(8'h12, 8'h34, 1'b0, s, c, lat);
    check("abort_restart_sum", s, 8'h46);
    check("abort_restart_carry_out", c, 0);

    // Random adds against an arithmetic model.
    for (int i = 0; i < 100; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref9 = 9'(ra) + 9'(rb) + 9'(rc);
      add8(ra, rb, rc, s, c, lat);
      check("rand_sum", s, ref9[7:0]);
      check("rand_carry_out", c, ref9[8]);
      check("rand_latency", lat, 5);
      sa   = ra[7] ? int'(ra) - 256 : int'(ra);
      sb   = rb[7] ? int'(rb) - 256 : int'(rb);
      ssum = sa + sb + int'(rc);
`ifdef TWO_BIT_SERIAL_OVF_EN
      check("rand_overflow", ovf, (ssum > 127 || ssum < -128) ? 1 : 0);
`endif
    end

    // Exhaustive WIDTH=4: done 3 edges after start.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          start4 = 1'b1; a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic);
          @(posedge clk);
          @(negedge clk);
          start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
          lat = 0;
          while (!done4 && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
          end
          check($sformatf("w4_%0d_%0d_%0d_result", ia, ib, ic), {co4, sum4}, ia + ib + ic);
          check($sformatf("w4_%0d_%0d_%0d_latency", ia, ib, ic), lat, 3);
`ifdef TWO_BIT_SERIAL_OVF_EN
          sa   = (ia > 7) ? ia - 16 : ia;
          sb   = (ib > 7) ? ib - 16 : ib;
          ssum = sa + sb + ic;
          check($sformatf("w4_%0d_%0d_%0d_overflow", ia, ib, ic), ovf4,
                (ssum > 7 || ssum < -8) ? 1 : 0);
`endif
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
